// File: rtl/shreg_pkg.sv
// Shared mode constants, level names and FSM state encoding for the
// shift-register sequencer and its capture helper.
package shreg_pkg;

   localparam logic [1:0] SHIFT     = 2'b00;
   localparam logic [1:0] ROTATE    = 2'b01;
   localparam logic [1:0] PARA_LOAD = 2'b10;

   localparam logic ENABLE = 1'b1;
   localparam logic HIGH   = 1'b1;
   localparam logic LOW    = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE,
      ST_GAP
   } state_e;

endpackage

// File: rtl/shreg_capture.sv
// Samples the shift register's serial output once per SHIFT cycle and packs
// the bits into RX_WORD, committing the word on the last sample.
module shreg_capture #(
   parameter int WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sampleEn_i,
   input  logic                       lastSample_i,
   input  logic                       dir_i,
   input  logic [$clog2(WIDTH)-1:0]   idx_i,
   input  logic                       sOut_i,
   output logic [WIDTH-1:0]           rxWord_o
);

   localparam int IW = $clog2(WIDTH);

   logic [WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0] shadow_d;
   logic [WIDTH-1:0] rxWord_q;
   logic [IW-1:0]    bitIdx;

   // The countdown index runs WIDTH-1..0, so sample k lands at WIDTH-1-idx;
   // a left shift delivers the word MSB first, which mirrors the position.
   always_comb begin
      bitIdx           = dir_i ? (IW'(WIDTH - 1) - idx_i) : idx_i;
      shadow_d         = shadow_q;
      shadow_d[bitIdx] = sOut_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         rxWord_q <= '0;
      end else if (sampleEn_i) begin
         shadow_q <= shadow_d;
         if (lastSample_i) begin
            rxWord_q <= shadow_d;
         end
      end
   end

   assign rxWord_o = rxWord_q;

endmodule

// File: rtl/shift_reg_seq.sv
// Sequencer driving a WIDTH-bit shift register: one PARA_LOAD cycle, WIDTH
// SHIFT cycles, a DONE pulse, then GAP idle cycles. SHREG_CAPTURE_EN adds RX_WORD.
module shift_reg_seq
   import shreg_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int GAP   = 0
) (
   input  logic             CLK,
   input  logic             RESET_L,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN_DATA,
   input  logic             IN_DIR,
   input  logic             IN_FILL,
   input  logic             ABORT,
   output logic             ENB,
   output logic             DIR,
   output logic             S_IN,
   output logic [1:0]       MODO,
   output logic [WIDTH-1:0] D,
   input  logic             S_OUT,
   output logic             BUSY,
   output logic             DONE
`ifdef SHREG_CAPTURE_EN
   ,
   output logic [WIDTH-1:0] RX_WORD
`endif
);

   localparam int             CW       = $clog2(WIDTH) + 1;
   localparam int             IW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
   localparam logic [3:0]     GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

   if (GAP < 0 || GAP > 15) begin : g_badGap
      $error("shift_reg_seq: GAP must lie within 0..15");
   end
   if (WIDTH < 2) begin : g_badWidth
      $error("shift_reg_seq: WIDTH must be at least 2");
   end

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [3:0]       gapCnt_q;
   logic             fill_q;
   logic             enb_q;
   logic             dir_q;
   logic             sIn_q;
   logic [1:0]       modo_q;
   logic [WIDTH-1:0] d_q;
   logic             busy_q;
   logic             done_q;

   // Outputs are registered alongside the state, so each branch sets the
   // values the shift register must see during the state being entered.
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         gapCnt_q <= '0;
         fill_q   <= LOW;
         enb_q    <= LOW;
         dir_q    <= HIGH;
         sIn_q    <= LOW;
         modo_q   <= PARA_LOAD;
         d_q      <= '0;
         busy_q   <= LOW;
         done_q   <= LOW;
      end else if (ABORT && state_q != ST_IDLE) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         gapCnt_q <= '0;
         enb_q    <= LOW;
         sIn_q    <= LOW;
         modo_q   <= PARA_LOAD;
         busy_q   <= LOW;
         done_q   <= LOW;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (IN_VALID && !ABORT) begin
                  state_q <= ST_LOAD;
                  d_q     <= IN_DATA;
                  dir_q   <= IN_DIR;
                  fill_q  <= IN_FILL;
                  enb_q   <= ENABLE;
                  modo_q  <= PARA_LOAD;
                  busy_q  <= HIGH;
               end
            end
            ST_LOAD: begin
               state_q <= ST_SHIFT;
               cnt_q   <= CNT_LAST;
               modo_q  <= SHIFT;
               sIn_q   <= fill_q;
            end
            ST_SHIFT: begin
               if (cnt_q == '0) begin
                  state_q <= ST_DONE;
                  enb_q   <= LOW;
                  modo_q  <= PARA_LOAD;
                  sIn_q   <= LOW;
                  done_q  <= HIGH;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            ST_DONE: begin
               done_q <= LOW;
               busy_q <= LOW;
               if (GAP > 0) begin
                  state_q  <= ST_GAP;
                  gapCnt_q <= GAP_LAST;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (gapCnt_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  gapCnt_q <= gapCnt_q - 4'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign IN_READY = (state_q == ST_IDLE);
   assign ENB      = enb_q;
   assign DIR      = dir_q;
   assign S_IN     = sIn_q;
   assign MODO     = modo_q;
   assign D        = d_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;

`ifdef SHREG_CAPTURE_EN
   // An abort on the final SHIFT cycle must not commit a partial word.
   shreg_capture #(
      .WIDTH(WIDTH)
   ) u_capture (
      .clk         (CLK),
      .rst_n       (RESET_L),
      .sampleEn_i  (state_q == ST_SHIFT && !ABORT),
      .lastSample_i(cnt_q == '0),
      .dir_i       (dir_q),
      .idx_i       (cnt_q[IW-1:0]),
      .sOut_i      (S_OUT),
      .rxWord_o    (RX_WORD)
   );
`else
   wire unused_sOut = S_OUT;
`endif

endmodule
